// File: rtl/kpscan_if.sv
// Keypad pin bundle plus the debounced key event seen by game control.
// master = scanner side (reads rows, drives columns and the key event).
interface kpscan_if;
    logic [3:0] kpr;
    logic [3:0] kpc;
    logic [3:0] num;
    logic       kphit;
    logic       kpress;

    modport master (input kpr, output kpc, output num, output kphit, output kpress);
    modport slave  (output kpr, input kpc, input num, input kphit, input kpress);
endinterface

// File: rtl/kpscan.sv
// 4x4 keypad scanner with press/release debounce; one kpress pulse per accepted key.
// Latency: 2-cycle row sync, kpress DEBOUNCE cycles after detection; no backpressure (event is fire-and-forget).
module kpscan #(
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 20000
) (
    input logic      clk,
    input logic      reset,
    kpscan_if.master kp
);

    localparam int CMAX = (SCAN_DIV > DEBOUNCE) ? SCAN_DIV : DEBOUNCE;
    localparam int CW   = $clog2(CMAX);
    localparam logic [CW-1:0] SCAN_END = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DEB_END  = CW'(DEBOUNCE - 1);

    typedef enum logic [1:0] {S_SCAN, S_DEB, S_HELD, S_REL} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [3:0]    kpr_m, kpr_s;
    logic [3:0]    rcap, rcap_n;
    logic [3:0]    kpc_q, kpc_n;
    logic [3:0]    num_q, num_n;
    logic          kphit_q, kphit_n;
    logic          kpress_q, kpress_n;
    logic          row_ok;
    logic [3:0]    kpc_rot;

    // Rows and columns are both active-low one-hot; bit 3 is index 0.
    function automatic logic [3:0] keymap(input logic [3:0] rows, input logic [3:0] cols);
        logic [1:0] r;
        logic [1:0] c;
        logic [3:0] code;
        r    = 2'd3;
        c    = 2'd3;
        code = 4'h0;
        case (rows)
            4'b0111: r = 2'd0;
            4'b1011: r = 2'd1;
            4'b1101: r = 2'd2;
            default: r = 2'd3;
        endcase
        case (cols)
            4'b0111: c = 2'd0;
            4'b1011: c = 2'd1;
            4'b1101: c = 2'd2;
            default: c = 2'd3;
        endcase
        case ({r, c})
            4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
            4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
            4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
            4'hC: code = 4'hE;  4'hD: code = 4'h0;  4'hE: code = 4'hF;  default: code = 4'hD;
        endcase
        return code;
    endfunction

    assign row_ok  = $onehot(~kpr_s);
    assign kpc_rot = {kpc_q[0], kpc_q[3:1]};

    always_ff @(posedge clk) begin
        if (reset) begin
            kpr_m    <= 4'hF;
            kpr_s    <= 4'hF;
            state    <= S_SCAN;
            cnt      <= '0;
            rcap     <= 4'hF;
            kpc_q    <= 4'b0111;
            num_q    <= 4'h0;
            kphit_q  <= 1'b0;
            kpress_q <= 1'b0;
        end else begin
            kpr_m    <= kp.kpr;
            kpr_s    <= kpr_m;
            state    <= state_n;
            cnt      <= cnt_n;
            rcap     <= rcap_n;
            kpc_q    <= kpc_n;
            num_q    <= num_n;
            kphit_q  <= kphit_n;
            kpress_q <= kpress_n;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        rcap_n   = rcap;
        kpc_n    = kpc_q;
        num_n    = num_q;
        kphit_n  = kphit_q;
        kpress_n = 1'b0;
        case (state)
            S_SCAN: begin
                if (cnt == SCAN_END) begin
                    cnt_n = '0;
                    if (row_ok) begin
                        rcap_n  = kpr_s;
                        state_n = S_DEB;
                    end else begin
                        kpc_n = kpc_rot;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_DEB: begin
                if (kpr_s != rcap) begin
                    kpc_n   = kpc_rot;
                    cnt_n   = '0;
                    state_n = S_SCAN;
                end else if (cnt == DEB_END) begin
                    num_n    = keymap(rcap, kpc_q);
                    kpress_n = 1'b1;
                    kphit_n  = 1'b1;
                    cnt_n    = '0;
                    state_n  = S_HELD;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_HELD: begin
                // Extra keys or a row change while held are deliberately ignored.
                if (kpr_s == 4'hF) begin
                    cnt_n   = '0;
                    state_n = S_REL;
                end
            end
            S_REL: begin
                if (kpr_s != 4'hF) begin
                    cnt_n   = '0;
                    state_n = S_HELD;
                end else if (cnt == DEB_END) begin
                    kphit_n = 1'b0;
                    kpc_n   = kpc_rot;
                    cnt_n   = '0;
                    state_n = S_SCAN;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                cnt_n   = '0;
                state_n = S_SCAN;
            end
        endcase
    end

    assign kp.kpc    = kpc_q;
    assign kp.num    = num_q;
    assign kp.kphit  = kphit_q;
    assign kp.kpress = kpress_q;

endmodule
